// File: rtl/sramlike_axi_arbiter_pkg.sv
// Shared definitions for the sram-like to AXI arbiter: FSM encoding, AXI
// constant fields and write-strobe generation.
package sramlike_axi_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  localparam logic [1:0] SIZE_BYTE      = 2'd0;
  localparam logic [1:0] SIZE_HALF      = 2'd1;
  localparam logic [1:0] SIZE_WORD      = 2'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [3:0] AXI_CACHE_NONE = 4'd0;
  localparam logic [2:0] AXI_PROT_NONE  = 3'd0;

  // Misaligned halves/words are not rejected; the shifted mask simply
  // falls off the top of the 4-bit strobe.
  function automatic logic [3:0] wstrb_gen(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SIZE_HALF: strb = 4'b0011 << addr_lo;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sramlike_axi_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting from the port after the last
// grantee; the pointer only advances when the grant is taken (en_i).
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 en_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    gnt_o = '0;
    idx_o = ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_PORTS);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  assign ptr_d = (en_i && (|req_i)) ? idx_o : ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= IDX_W'(NUM_PORTS - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sramlike_axi_arbiter.sv
// Multi-port sram-like to single AXI master bridge; one transaction in
// flight, round-robin arbitration between ports.
module sramlike_axi_arbiter
  import sramlike_axi_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ID_W      = 4,
  parameter int DATA_W    = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        wr,
  input  logic [2*NUM_PORTS-1:0]      size,
  input  logic [32*NUM_PORTS-1:0]     addr,
  input  logic [DATA_W*NUM_PORTS-1:0] sram_wdata,
  output logic [NUM_PORTS-1:0]        addr_ok,
  output logic [NUM_PORTS-1:0]        data_ok,
  output logic [DATA_W-1:0]           sram_rdata,
  output logic                        err,
  output logic [ID_W-1:0]             arid,
  output logic [31:0]                 araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arlock,
  output logic [3:0]                  arcache,
  output logic [2:0]                  arprot,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [ID_W-1:0]             rid,
  input  logic [DATA_W-1:0]           rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  output logic [ID_W-1:0]             awid,
  output logic [31:0]                 awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awlock,
  output logic [3:0]                  awcache,
  output logic [2:0]                  awprot,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [ID_W-1:0]             wid,
  output logic [DATA_W-1:0]           wdata,
  output logic [3:0]                  wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [ID_W-1:0]             bid,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e                state_q, state_d;
  logic [NUM_PORTS-1:0]  gnt, gnt_q;
  logic [IDX_W-1:0]      gnt_idx, idx_q;
  logic                  grant_en;
  logic [31:0]           addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  wr_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]  data_ok_q, data_ok_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  err_q, err_d;
  logic                  unused_axi;

  // Transaction IDs are redundant with a single outstanding transfer.
  assign unused_axi = ^{rid, bid, rlast};

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .req_i  (req),
    .en_i   (grant_en),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  always_comb begin
    addr_d  = '0;
    size_d  = '0;
    wdata_d = '0;
    wr_d    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        addr_d  = addr[32*i +: 32];
        size_d  = size[2*i +: 2];
        wdata_d = sram_wdata[DATA_W*i +: DATA_W];
        wr_d    = wr[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_en  = 1'b0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    data_ok_d = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_en  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = wr_d ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) begin
          rdata_d   = rdata;
          data_ok_d = gnt_q;
          err_d     = err_q | (|rresp);
          state_d   = IDLE;
        end
      end
      WR_REQ: begin
        // AW and W handshake independently; leave once both have completed.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          data_ok_d = gnt_q;
          err_d     = err_q | (|bresp);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      data_ok_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      data_ok_q <= data_ok_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      if (grant_en) begin
        gnt_q   <= gnt;
        idx_q   <= gnt_idx;
        addr_q  <= addr_d;
        size_q  <= size_d;
        wdata_q <= wdata_d;
      end
    end
  end

  // Grant pulse is combinational, so it is also masked while reset is held.
  assign addr_ok    = (state_q == IDLE && aresetn) ? gnt : '0;
  assign data_ok    = data_ok_q;
  assign sram_rdata = rdata_q;
  assign err        = err_q;

  assign arid    = ID_W'(idx_q);
  assign araddr  = addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = {1'b0, size_q};
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 1'b0;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;
  assign arvalid = (state_q == RD_ADDR);
  assign rready  = (state_q == RD_DATA);

  assign awid    = ID_W'(idx_q);
  assign awaddr  = addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = {1'b0, size_q};
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 1'b0;
  assign awcache = AXI_CACHE_NONE;
  assign awprot  = AXI_PROT_NONE;
  assign awvalid = (state_q == WR_REQ) && !aw_done_q;

  assign wid    = ID_W'(idx_q);
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_gen(size_q, addr_q[1:0]);
  assign wlast  = 1'b1;
  assign wvalid = (state_q == WR_REQ) && !w_done_q;
  assign bready = (state_q == WR_RESP);

endmodule

// File: tb/tb_sramlike_axi_arbiter.sv
// Directed bench: 2-port instance driven by a scripted AXI slave, plus a
// 4-port instance with an always-ready slave for round-robin fairness.
module tb_sramlike_axi_arbiter;

  logic        aclk, aresetn;
  int          n_chk, n_fail;

  logic [1:0]  s_req, s_wr, s_addr_ok, s_data_ok;
  logic [3:0]  s_size;
  logic [63:0] s_addr, s_wdata;
  logic [31:0] s_rdata;
  logic        err;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arlock, arvalid, arready, rlast, rvalid, rready;
  logic        awlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  logic [3:0]   q_req, q_wr, q_addr_ok, q_data_ok;
  logic [7:0]   q_size;
  logic [127:0] q_addr, q_wdata;
  logic [31:0]  q_srdata, q_araddr, q_rdata, q_awaddr, q_wdata_o;
  logic         q_err;
  logic [3:0]   q_arid, q_rid, q_awid, q_wid, q_bid;
  logic [7:0]   q_arlen, q_awlen;
  logic [2:0]   q_arsize, q_arprot, q_awsize, q_awprot;
  logic [1:0]   q_arburst, q_rresp, q_awburst, q_bresp;
  logic [3:0]   q_arcache, q_awcache, q_wstrb;
  logic         q_arlock, q_arvalid, q_arready, q_rlast, q_rvalid, q_rready;
  logic         q_awlock, q_awvalid, q_awready, q_wlast, q_wvalid, q_wready;
  logic         q_bvalid, q_bready;

  sramlike_axi_arbiter #(.NUM_PORTS(2), .ID_W(4), .DATA_W(32)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .req(s_req), .wr(s_wr), .size(s_size),
    .addr(s_addr), .sram_wdata(s_wdata), .addr_ok(s_addr_ok), .data_ok(s_data_ok),
    .sram_rdata(s_rdata), .err(err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  sramlike_axi_arbiter #(.NUM_PORTS(4), .ID_W(4), .DATA_W(32)) u_dut4 (
    .aclk(aclk), .aresetn(aresetn), .req(q_req), .wr(q_wr), .size(q_size),
    .addr(q_addr), .sram_wdata(q_wdata), .addr_ok(q_addr_ok), .data_ok(q_data_ok),
    .sram_rdata(q_srdata), .err(q_err),
    .arid(q_arid), .araddr(q_araddr), .arlen(q_arlen), .arsize(q_arsize),
    .arburst(q_arburst), .arlock(q_arlock), .arcache(q_arcache), .arprot(q_arprot),
    .arvalid(q_arvalid), .arready(q_arready), .rid(q_rid), .rdata(q_rdata),
    .rresp(q_rresp), .rlast(q_rlast), .rvalid(q_rvalid), .rready(q_rready),
    .awid(q_awid), .awaddr(q_awaddr), .awlen(q_awlen), .awsize(q_awsize),
    .awburst(q_awburst), .awlock(q_awlock), .awcache(q_awcache), .awprot(q_awprot),
    .awvalid(q_awvalid), .awready(q_awready), .wid(q_wid), .wdata(q_wdata_o),
    .wstrb(q_wstrb), .wlast(q_wlast), .wvalid(q_wvalid), .wready(q_wready),
    .bid(q_bid), .bresp(q_bresp), .bvalid(q_bvalid), .bready(q_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Single write with an immediately-ready slave: addr_ok, AW+W, B, data_ok.
  task automatic do_write(input int p, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] d, input logic [3:0] strb);
    logic [1:0] oh;
    oh = 2'b00;
    oh[p] = 1'b1;
    @(negedge aclk);
    s_req = oh; s_wr = oh;
    s_size[2*p +: 2] = sz; s_addr[32*p +: 32] = a; s_wdata[32*p +: 32] = d;
    #1 check_eq("wr_addr_ok", 64'(s_addr_ok), 64'(oh));
    @(negedge aclk);
    s_req = 2'b00; awready = 1'b1; wready = 1'b1;
    #1 check_eq("wr_awvalid", 64'(awvalid), 64'd1);
    check_eq("wr_wvalid", 64'(wvalid), 64'd1);
    check_eq("wr_awaddr", 64'(awaddr), 64'(a));
    check_eq("wr_awsize", 64'(awsize), 64'({1'b0, sz}));
    check_eq("wr_wstrb", 64'(wstrb), 64'(strb));
    check_eq("wr_wdata", 64'(wdata), 64'(d));
    check_eq("wr_awid", 64'(awid), 64'(p));
    @(negedge aclk);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    #1 check_eq("wr_bready", 64'(bready), 64'd1);
    check_eq("wr_aw_dropped", 64'({awvalid, wvalid}), 64'd0);
    @(negedge aclk);
    bvalid = 1'b0; s_wr = 2'b00;
    #1 check_eq("wr_data_ok", 64'(s_data_ok), 64'(oh));
  endtask

  initial begin
    logic [3:0] seq [5];
    logic [3:0] exp4 [5];
    int         ng;
    n_chk = 0; n_fail = 0; ng = 0;
    exp4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    aresetn = 1'b0;
    s_req = 2'b11; s_wr = '0; s_size = '0; s_addr = '0; s_wdata = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rid = '0; rlast = 1'b1;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;
    q_req = 4'hF; q_wr = '0; q_size = 8'hAA; q_addr = '0; q_wdata = '0;
    q_arready = 1'b1; q_rvalid = 1'b1; q_rdata = '0; q_rresp = '0; q_rid = '0;
    q_rlast = 1'b1; q_awready = 1'b1; q_wready = 1'b1; q_bvalid = 1'b1;
    q_bresp = '0; q_bid = '0;

    // Reset: every valid/ready/pulse low even with requests pending
    repeat (2) @(negedge aclk);
    #1 check_eq("rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
    check_eq("rst_addr_ok", 64'(s_addr_ok), 64'd0);
    check_eq("rst_addr_ok4", 64'(q_addr_ok), 64'd0);
    check_eq("rst_data_ok", 64'(s_data_ok), 64'd0);
    check_eq("rst_err_rdata", 64'({err, s_rdata}), 64'd0);

    @(negedge aclk);
    aresetn = 1'b1; s_req = 2'b00;
    // 4 ports all requesting: grants rotate 0,1,2,3,0
    for (int c = 0; c < 40 && ng < 5; c++) begin
      if (c > 0) @(negedge aclk);
      #1;
      if (q_addr_ok != 4'b0000) begin
        seq[ng] = q_addr_ok;
        ng++;
      end
    end
    check_eq("rr4_grant_count", 64'(ng), 64'd5);
    for (int k = 0; k < 5; k++) check_eq("rr4_grant_seq", 64'(seq[k]), 64'(exp4[k]));

    // Two simultaneous reads: port 0 first, port 1 granted with port 0's data_ok
    @(negedge aclk);
    s_req = 2'b11; s_wr = 2'b00; s_size = 4'b1010;
    s_addr = {32'h1FC0_0004, 32'h1FC0_0000};
    #1 check_eq("rd0_addr_ok", 64'(s_addr_ok), 64'b01);
    @(negedge aclk);
    s_req = 2'b10; arready = 1'b1;
    #1 check_eq("rd0_arvalid", 64'(arvalid), 64'd1);
    check_eq("rd0_araddr", 64'(araddr), 64'h1FC0_0000);
    check_eq("rd0_arid", 64'(arid), 64'd0);
    check_eq("rd0_arsize", 64'(arsize), 64'd2);
    check_eq("rd0_no_addr_ok", 64'(s_addr_ok), 64'd0);
    @(negedge aclk);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111;
    #1 check_eq("rd0_rready", 64'(rready), 64'd1);
    check_eq("rd0_ar_dropped", 64'(arvalid), 64'd0);
    @(negedge aclk);
    rvalid = 1'b0;
    #1 check_eq("rd0_data_ok", 64'(s_data_ok), 64'b01);
    check_eq("rd0_rdata", 64'(s_rdata), 64'h1111_1111);
    check_eq("rd1_addr_ok", 64'(s_addr_ok), 64'b10);
    @(negedge aclk);
    s_req = 2'b00; arready = 1'b1;
    #1 check_eq("rd1_arid", 64'(arid), 64'd1);
    check_eq("rd1_araddr", 64'(araddr), 64'h1FC0_0004);
    check_eq("rd1_data_ok_once", 64'(s_data_ok), 64'd0);
    @(negedge aclk);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h2222_2222; rresp = 2'b10;
    #1 check_eq("rd1_err_before", 64'(err), 64'd0);
    @(negedge aclk);
    rvalid = 1'b0; rresp = 2'b00;
    #1 check_eq("rd1_data_ok", 64'(s_data_ok), 64'b10);
    check_eq("rd1_rdata", 64'(s_rdata), 64'h2222_2222);
    check_eq("rd1_err_set", 64'(err), 64'd1);

    // Writes with the fastest slave: strobe shapes incl. misaligned
    do_write(0, 32'h0000_0102, 2'd1, 32'h1234_5678, 4'b1100);
    do_write(1, 32'h0000_0003, 2'd1, 32'hCAFE_F00D, 4'b1000);
    do_write(0, 32'h0000_0001, 2'd2, 32'h0BAD_BEEF, 4'b1111);

    // Byte write; awready answers 4 cycles after wready
    @(negedge aclk);
    s_req = 2'b10; s_wr = 2'b10; s_size[3:2] = 2'd0;
    s_addr[63:32] = 32'h0000_0003; s_wdata[63:32] = 32'hAABB_CCDD;
    #1 check_eq("bw_addr_ok", 64'(s_addr_ok), 64'b10);
    @(negedge aclk);
    s_req = 2'b00; wready = 1'b1; awready = 1'b0;
    #1 check_eq("bw_both_valid", 64'({awvalid, wvalid}), 64'b11);
    check_eq("bw_awsize", 64'(awsize), 64'd0);
    check_eq("bw_wstrb", 64'(wstrb), 64'b1000);
    check_eq("bw_wdata", 64'(wdata), 64'hAABB_CCDD);
    for (int k = 1; k <= 3; k++) begin
      @(negedge aclk);
      wready = 1'b0;
      #1 check_eq("bw_aw_held_w_dropped", 64'({awvalid, wvalid, bready}), 64'b100);
    end
    @(negedge aclk);
    awready = 1'b1;
    #1 check_eq("bw_awvalid_at_ready", 64'(awvalid), 64'd1);
    @(negedge aclk);
    awready = 1'b0; bvalid = 1'b1;
    #1 check_eq("bw_bready", 64'({bready, awvalid}), 64'b10);
    check_eq("bw_no_early_data_ok", 64'(s_data_ok), 64'd0);
    @(negedge aclk);
    bvalid = 1'b0; s_wr = 2'b00;
    #1 check_eq("bw_data_ok", 64'(s_data_ok), 64'b10);
    repeat (2) begin
      @(negedge aclk);
      #1 check_eq("bw_single_data_ok", 64'(s_data_ok), 64'd0);
    end
    check_eq("err_sticky", 64'(err), 64'd1);

    // Reset during RD_DATA after port 0 was last granted
    @(negedge aclk);
    s_req = 2'b01; s_addr[31:0] = 32'h0000_0040;
    #1 check_eq("rst_rd_addr_ok", 64'(s_addr_ok), 64'b01);
    @(negedge aclk);
    s_req = 2'b00; arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    #1 check_eq("rst_rd_in_rdata", 64'(rready), 64'd1);
    #1 aresetn = 1'b0;
    #1 check_eq("async_rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
    check_eq("async_rst_err_rdata", 64'({err, s_rdata}), 64'd0);
    check_eq("async_rst_data_ok", 64'(s_data_ok), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1; s_req = 2'b11;
    #1 check_eq("post_rst_grant_port0", 64'(s_addr_ok), 64'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
